// File: rtl/quadrilatero_pkg.sv
// quadrilatero_pkg: shared types and sizes for the quadrilatero dispatch stage.
package quadrilatero_pkg;
    localparam int N_REGS                = 8;
    localparam int RW                    = $clog2(N_REGS);
    localparam int MAX_NUM_READ_OPERANDS = 3;
    localparam int OPW                   = $clog2(MAX_NUM_READ_OPERANDS);
    localparam int NUM_FU                = 3;
    localparam int RD_CNT_W              = 2;

    typedef enum logic [1:0] {SA = 2'd0, LSU = 2'd1, RF = 2'd2} execution_units_t;

    typedef enum logic {EMPTY, FULL} slot_state_t;

    typedef struct packed {
        logic [OPW-1:0]                            n_ops;
        logic [MAX_NUM_READ_OPERANDS-1:0][RW-1:0]  rd_regs;
        logic [RW-1:0]                             wb_reg;
        logic                                      wb_en;
        execution_units_t                          exec_unit;
        logic [1:0]                                datatype;
        logic                                      is_store;
        logic                                      is_float;
        logic [3:0]                                id;
    } dispatch_req_t;
endpackage

// File: rtl/quadrilatero_scoreboard.sv
// quadrilatero_scoreboard: per-register write-busy bits and pending-read counters with hazard query.
module quadrilatero_scoreboard
    import quadrilatero_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  dispatch_req_t                    req_i,
    input  logic                             issue_i,
    input  logic [NUM_FU-1:0][N_REGS-1:0]    rd_done_i,
    input  logic [NUM_FU-1:0]                wb_done_valid_i,
    input  logic [NUM_FU-1:0][RW-1:0]        wb_done_reg_i,
    output logic                             hazard_o,
    output logic                             clear_next_o
);
    localparam logic [RD_CNT_W:0] CNT_MAX = (RD_CNT_W+1)'((1 << RD_CNT_W) - 1);

    logic [N_REGS-1:0]                busy_w, busy_n, busy_set, busy_clr;
    logic [N_REGS-1:0][RD_CNT_W-1:0]  rd_cnt, rd_cnt_n;
    logic [N_REGS-1:0][RD_CNT_W:0]    add, rel, sum;

    always_comb begin
        add      = '0;
        rel      = '0;
        sum      = '0;
        busy_set = '0;
        busy_clr = '0;
        hazard_o = 1'b0;
        rd_cnt_n = '0;
        for (int i = 0; i < MAX_NUM_READ_OPERANDS; i++)
            if (OPW'(i) < req_i.n_ops)
                add[req_i.rd_regs[i]] = add[req_i.rd_regs[i]] + 1'b1;
        for (int f = 0; f < NUM_FU; f++) begin
            if (wb_done_valid_i[f])
                busy_clr[wb_done_reg_i[f]] = 1'b1;
            for (int r = 0; r < N_REGS; r++)
                rel[r] = rel[r] + {{RD_CNT_W{1'b0}}, rd_done_i[f][r]};
        end
        busy_set[req_i.wb_reg] = issue_i && req_i.wb_en;
        // a read that would push its counter past the top is treated like a busy register
        for (int r = 0; r < N_REGS; r++) begin
            hazard_o = hazard_o || ((add[r] != '0) && (busy_w[r] || ({1'b0, rd_cnt[r]} + add[r] > CNT_MAX)));
            sum[r] = {1'b0, rd_cnt[r]} + (issue_i ? add[r] : '0);
            rd_cnt_n[r] = (sum[r] > rel[r]) ? RD_CNT_W'(sum[r] - rel[r]) : '0;
        end
        hazard_o = hazard_o || (req_i.wb_en && (busy_w[req_i.wb_reg] || rd_cnt[req_i.wb_reg] != '0));
        busy_n = (busy_w & ~busy_clr) | busy_set;
        clear_next_o = (busy_n == '0) && (rd_cnt_n == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_w <= '0;
            rd_cnt <= '0;
        end else begin
            busy_w <= busy_n;
            rd_cnt <= rd_cnt_n;
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            for (int f = 0; f < NUM_FU; f++)
                assert (!wb_done_valid_i[f] || busy_w[wb_done_reg_i[f]])
                    else $warning("writeback release of a register that is not busy");
            for (int r = 0; r < N_REGS; r++)
                assert (rel[r] <= sum[r])
                    else $warning("read release of a register with no pending reads");
        end
    end
endmodule

// File: rtl/quadrilatero_dispatcher.sv
// quadrilatero_dispatcher: one-slot in-order issue stage with scoreboard hazard checks.
// Define QUADRILATERO_DISPATCH_PERF_EN to add issue/stall performance counters.
module quadrilatero_dispatcher
    import quadrilatero_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             instr_valid_i,
    output logic                             instr_ready_o,
    input  dispatch_req_t                    instr_i,
    output logic [NUM_FU-1:0]                issue_valid_o,
    input  logic [NUM_FU-1:0]                issue_ready_i,
    output dispatch_req_t                    issue_o,
    input  logic [NUM_FU-1:0][N_REGS-1:0]    rd_done_i,
    input  logic [NUM_FU-1:0]                wb_done_valid_i,
    input  logic [NUM_FU-1:0][RW-1:0]        wb_done_reg_i,
    output logic                             idle_o
`ifdef QUADRILATERO_DISPATCH_PERF_EN
    ,
    output logic [31:0]                      perf_issued_o,
    output logic [31:0]                      perf_hazard_stall_o,
    output logic [31:0]                      perf_fu_stall_o
`endif
);
    slot_state_t state;
    logic full, hazard, fire, accept, load, empty_n, sb_clear_next;

    always_comb begin
        full          = state == FULL;
        issue_valid_o = (full && !hazard) ? NUM_FU'(1 << issue_o.exec_unit) : '0;
        fire          = |(issue_valid_o & issue_ready_i);
        instr_ready_o = !full || fire;
        accept        = instr_valid_i && instr_ready_o;
        load          = accept && (int'(instr_i.exec_unit) < NUM_FU);
        empty_n       = instr_ready_o ? !load : 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= EMPTY;
            issue_o <= '0;
            idle_o  <= 1'b1;
        end else begin
            if (instr_ready_o) begin
                state   <= load ? FULL : EMPTY;
                issue_o <= load ? instr_i : '0;
            end
            idle_o <= empty_n && sb_clear_next;
        end
    end

    quadrilatero_scoreboard u_scoreboard (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_i           (issue_o),
        .issue_i         (fire),
        .rd_done_i       (rd_done_i),
        .wb_done_valid_i (wb_done_valid_i),
        .wb_done_reg_i   (wb_done_reg_i),
        .hazard_o        (hazard),
        .clear_next_o    (sb_clear_next)
    );

`ifdef QUADRILATERO_DISPATCH_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_issued_o       <= '0;
            perf_hazard_stall_o <= '0;
            perf_fu_stall_o     <= '0;
        end else begin
            perf_issued_o       <= perf_issued_o + 32'(fire);
            perf_hazard_stall_o <= perf_hazard_stall_o + 32'(full && hazard);
            perf_fu_stall_o     <= perf_fu_stall_o + 32'(|(issue_valid_o & ~issue_ready_i));
        end
    end
`endif

    always @(posedge clk_i) begin
        if (!rst_i && accept)
            assert (int'(instr_i.exec_unit) < NUM_FU)
                else $error("instruction with unknown exec_unit dropped");
    end
endmodule

// File: tb/tb_quadrilatero_dispatcher.sv
// tb_quadrilatero_dispatcher: directed scenarios checked against a behavioural scoreboard model.
module tb_quadrilatero_dispatcher;
    import quadrilatero_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic instr_valid;
    logic instr_ready;
    dispatch_req_t instr;
    logic [NUM_FU-1:0] issue_valid;
    logic [NUM_FU-1:0] issue_ready;
    dispatch_req_t issue;
    logic [NUM_FU-1:0][N_REGS-1:0] rd_done;
    logic [NUM_FU-1:0] wb_done_valid;
    logic [NUM_FU-1:0][RW-1:0] wb_done_reg;
    logic idle;
`ifdef QUADRILATERO_DISPATCH_PERF_EN
    logic [31:0] perf_issued, perf_hazard_stall, perf_fu_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    quadrilatero_dispatcher dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .instr_valid_i   (instr_valid),
        .instr_ready_o   (instr_ready),
        .instr_i         (instr),
        .issue_valid_o   (issue_valid),
        .issue_ready_i   (issue_ready),
        .issue_o         (issue),
        .rd_done_i       (rd_done),
        .wb_done_valid_i (wb_done_valid),
        .wb_done_reg_i   (wb_done_reg),
        .idle_o          (idle)
`ifdef QUADRILATERO_DISPATCH_PERF_EN
        ,
        .perf_issued_o       (perf_issued),
        .perf_hazard_stall_o (perf_hazard_stall),
        .perf_fu_stall_o     (perf_fu_stall)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one slot plus per-register busy flags and pending-read counts.
    bit            m_full;
    dispatch_req_t m_slot;
    bit            m_busy [N_REGS];
    int            m_cnt  [N_REGS];
    int            m_issued;
    bit            m_f, m_acc;
    int            m_rel;

    function automatic int m_uses(input int r);
        int n = 0;
        for (int i = 0; i < MAX_NUM_READ_OPERANDS; i++)
            if (i < int'(m_slot.n_ops) && int'(m_slot.rd_regs[i]) == r) n++;
        return n;
    endfunction

    function automatic bit m_hazard();
        bit h = 0;
        for (int r = 0; r < N_REGS; r++)
            if (m_uses(r) > 0 && (m_busy[r] || m_cnt[r] + m_uses(r) > (1 << RD_CNT_W) - 1)) h = 1;
        if (m_slot.wb_en && (m_busy[m_slot.wb_reg] || m_cnt[m_slot.wb_reg] != 0)) h = 1;
        return h;
    endfunction

    function automatic logic [NUM_FU-1:0] m_valid();
        return (m_full && !m_hazard()) ? NUM_FU'(1 << m_slot.exec_unit) : '0;
    endfunction

    function automatic bit m_idle();
        bit c = !m_full;
        for (int r = 0; r < N_REGS; r++) if (m_busy[r] || m_cnt[r] != 0) c = 0;
        return c;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full = 0;
            m_slot = '0;
            m_issued = 0;
            for (int r = 0; r < N_REGS; r++) begin
                m_busy[r] = 0;
                m_cnt[r]  = 0;
            end
        end else begin
            m_f   = |(m_valid() & issue_ready);
            m_acc = !m_full || m_f;
            for (int r = 0; r < N_REGS; r++) begin
                m_rel = 0;
                for (int f = 0; f < NUM_FU; f++) m_rel += int'(rd_done[f][r]);
                m_cnt[r] = m_cnt[r] + (m_f ? m_uses(r) : 0) - m_rel;
                if (m_cnt[r] < 0) m_cnt[r] = 0;
            end
            for (int f = 0; f < NUM_FU; f++) if (wb_done_valid[f]) m_busy[wb_done_reg[f]] = 0;
            if (m_f && m_slot.wb_en) m_busy[m_slot.wb_reg] = 1;
            if (m_f) m_issued++;
            if (m_acc) begin
                m_full = instr_valid && int'(instr.exec_unit) < NUM_FU;
                m_slot = m_full ? instr : '0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model issue_valid", 32'(issue_valid), 32'(m_valid()));
        chk("model instr_ready", 32'(instr_ready), 32'(!m_full || |(m_valid() & issue_ready)));
        chk("model issue_o", 32'(issue), 32'(m_full ? m_slot : '0));
        chk("model idle", 32'(idle), 32'(m_idle()));
    end

    function automatic dispatch_req_t mk(input execution_units_t eu, input int n, input int r0,
                                         input int r1, input int r2, input int wb, input bit en,
                                         input int id);
        dispatch_req_t q = '0;
        q.exec_unit  = eu;
        q.n_ops      = OPW'(n);
        q.rd_regs[0] = RW'(r0);
        q.rd_regs[1] = RW'(r1);
        q.rd_regs[2] = RW'(r2);
        q.wb_reg     = RW'(wb);
        q.wb_en      = en;
        q.id         = 4'(id);
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        instr_valid   = 1'b0;
        rd_done       = '0;
        wb_done_valid = '0;
        wb_done_reg   = '0;
    endtask

    task automatic wb(input int fu, input int r);
        wb_done_valid[fu] = 1'b1;
        wb_done_reg[fu]   = RW'(r);
    endtask

    dispatch_req_t st5;

    initial begin
        instr_valid = 0; instr = '0; issue_ready = '1;
        rd_done = '0; wb_done_valid = '0; wb_done_reg = '0;
        tick(); tick();
        @(negedge clk);
        chk("reset ready", 32'(instr_ready), 32'd1);
        chk("reset idle", 32'(idle), 32'd1);
        chk("reset valid", 32'(issue_valid), 32'd0);
        chk("reset issue_o", 32'(issue), 32'd0);
        tick();
        rst = 1'b0;
        // back-to-back independent loads
        instr_valid = 1; instr = mk(LSU, 0, 0, 0, 0, 1, 1, 1);
        @(negedge clk); chk("t1 ready first", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1; instr = mk(LSU, 0, 0, 0, 0, 2, 1, 2);
        @(negedge clk);
        chk("t1 valid m1", 32'(issue_valid), 32'b010);
        chk("t1 id m1", 32'(issue.id), 32'd1);
        chk("t1 ready pass", 32'(instr_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("t1 valid m2", 32'(issue_valid), 32'b010);
        chk("t1 id m2", 32'(issue.id), 32'd2);
        tick();
        wb(1, 2);
        @(negedge clk); chk("t1 busy not idle", 32'(idle), 32'd0);
        tick();
        // MAC waits for load of m1
        instr_valid = 1; instr = mk(SA, 3, 0, 1, 2, 0, 1, 3);
        tick();
        @(negedge clk);
        chk("t2 raw held", 32'(issue_valid), 32'd0);
        chk("t2 ready low", 32'(instr_ready), 32'd0);
        tick();
        wb(1, 1);
        @(negedge clk); chk("t2 no bypass", 32'(issue_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("t2 issue sa", 32'(issue_valid), 32'b001);
        chk("t2 id", 32'(issue.id), 32'd3);
        tick();
        rd_done[0] = 8'h07; wb(0, 0);
        tick();
        @(negedge clk); chk("t2 idle", 32'(idle), 32'd1);
        // WAR: MZERO m3 behind a reader of m3
        instr_valid = 1; instr = mk(SA, 2, 0, 3, 0, 0, 1, 4);
        tick();
        instr_valid = 1; instr = mk(RF, 0, 0, 0, 0, 3, 1, 5);
        @(negedge clk); chk("t3 mmasa issue", 32'(issue_valid), 32'b001);
        tick();
        @(negedge clk);
        chk("t3 war held", 32'(issue_valid), 32'd0);
        chk("t3 held id", 32'(issue.id), 32'd5);
        tick();
        rd_done[0] = 8'h08;
        @(negedge clk); chk("t3 war same cycle", 32'(issue_valid), 32'd0);
        tick();
        @(negedge clk); chk("t3 rf issue", 32'(issue_valid), 32'b100);
        tick();
        rd_done[0] = 8'h01; wb(0, 0); wb(2, 3);
        tick();
        @(negedge clk); chk("t3 idle", 32'(idle), 32'd1);
        // store held by a stalled LSU
        issue_ready = 3'b101;
        st5 = mk(LSU, 1, 5, 0, 0, 0, 0, 6);
        instr_valid = 1; instr = st5;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4 stall valid", 32'(issue_valid), 32'b010);
            chk("t4 stable payload", 32'(issue), 32'(st5));
            chk("t4 ready low", 32'(instr_ready), 32'd0);
            tick();
        end
        issue_ready = '1;
        @(negedge clk);
        chk("t4 fire valid", 32'(issue_valid), 32'b010);
        chk("t4 fire ready", 32'(instr_ready), 32'd1);
        tick();
        rd_done[1] = 8'h20;
        tick();
        // release and issue on m2 in one cycle, then a spurious writeback
        instr_valid = 1; instr = mk(LSU, 1, 2, 0, 0, 0, 0, 7);
        tick();
        tick();
        instr_valid = 1; instr = mk(LSU, 1, 2, 0, 0, 0, 0, 8);
        tick();
        rd_done[1] = 8'h04;
        @(negedge clk); chk("t5 second read", 32'(issue_valid), 32'b010);
        tick();
        instr_valid = 1; instr = mk(RF, 0, 0, 0, 0, 2, 1, 9);
        @(negedge clk); chk("t5 cnt kept", 32'(idle), 32'd0);
        tick();
        wb(2, 7);
        @(negedge clk); chk("t5 war cnt one", 32'(issue_valid), 32'd0);
        tick();
        rd_done[1] = 8'h04;
        @(negedge clk); chk("t5 spurious ignored", 32'(issue_valid), 32'd0);
        tick();
        @(negedge clk); chk("t5 mzero issue", 32'(issue_valid), 32'b100);
        tick();
        wb(2, 2);
        tick();
        @(negedge clk); chk("t5 idle", 32'(idle), 32'd1);
        // reset while the slot holds a blocked instruction
        instr_valid = 1; instr = mk(LSU, 0, 0, 0, 0, 4, 1, 10);
        tick();
        instr_valid = 1; instr = mk(SA, 1, 4, 0, 0, 5, 1, 11);
        @(negedge clk); chk("t6 load m4", 32'(issue_valid), 32'b010);
        tick();
        @(negedge clk);
        chk("t6 blocked", 32'(issue_valid), 32'd0);
        chk("t6 busy", 32'(idle), 32'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6 rst valid", 32'(issue_valid), 32'd0);
        chk("t6 rst idle", 32'(idle), 32'd1);
        chk("t6 rst ready", 32'(instr_ready), 32'd1);
        tick();
        rst = 1'b0;
        instr_valid = 1; instr = mk(RF, 0, 0, 0, 0, 4, 1, 12);
        tick();
        @(negedge clk);
        chk("t6 mzero at once", 32'(issue_valid), 32'b100);
        chk("t6 mzero id", 32'(issue.id), 32'd12);
`ifdef QUADRILATERO_DISPATCH_PERF_EN
        chk("perf issued", perf_issued, 32'(m_issued));
`endif
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
